// File: rtl/host_cmd_loader.sv
// host_cmd_loader: parses 3-byte host headers from the UART, streams payload
// bytes into the data/weight/op BRAMs as full words, reads words back out over
// the UART transmitter, and launches the CPU.
// Optional feature macro: LOADER_AUTORUN_EN -- completing an op write starts the
// CPU without a separate run command.
module host_cmd_loader #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned WEIGHT_SIZE  = 96,
  parameter int unsigned OP_SIZE      = 8,
  parameter int unsigned DATA_ADDRS   = 2,
  parameter int unsigned WEIGHT_ADDRS = 2,
  parameter int unsigned OP_ADDRS     = 12,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned MAX_SIZE =
    ((DATA_SIZE > WEIGHT_SIZE ? DATA_SIZE : WEIGHT_SIZE) > OP_SIZE) ?
    (DATA_SIZE > WEIGHT_SIZE ? DATA_SIZE : WEIGHT_SIZE) : OP_SIZE
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic [1:0]          mem_sel,
  output logic [15:0]         mem_addr,
  output logic [MAX_SIZE-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [MAX_SIZE-1:0] mem_rdata,
  output logic                cpu_start,
  input  logic                cpu_done,
  output logic                busy,
  output logic                err
);

  localparam int unsigned MAX_BYTES = MAX_SIZE / 8;
  localparam int unsigned BCNT_W    = $clog2(MAX_BYTES + 1);
  localparam int unsigned WAIT_W    = $clog2(READ_LATENCY + 1);

  localparam logic [7:0] CMD_WR_DATA   = 8'h00;
  localparam logic [7:0] CMD_WR_WEIGHT = 8'h01;
  localparam logic [7:0] CMD_RUN       = 8'h02;
  localparam logic [7:0] CMD_WR_OP     = 8'h03;
  localparam logic [7:0] CMD_RD_DATA   = 8'h04;
  localparam logic [7:0] CMD_RD_WEIGHT = 8'h05;

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_WEIGHT = 2'd1;
  localparam logic [1:0] SEL_OP     = 2'd3;

  typedef enum logic [3:0] {
    HDR0, HDR1, HDR2, WR_BYTES, WR_COMMIT, RD_ISSUE, RD_WAIT, RD_SEND, RUN_WAIT
  } state_t;

  state_t              r_state;
  logic [7:0]          r_cmd;
  logic [15:0]         r_count;
  logic [16:0]         r_word_cnt;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic [WAIT_W-1:0]   r_wait;
  logic [15:0]         r_addr;
  logic [1:0]          r_sel;
  logic [MAX_SIZE-1:0] r_wdata;
  logic [MAX_SIZE-1:0] r_rbuf;
  logic                r_we;
  logic                r_re;
  logic                r_tx_valid;
  logic [7:0]          r_tx_data;
  logic                r_cpu_start;
  logic                r_busy;
  logic                r_err;

  // Bytes per word of the selected memory.
  function automatic logic [BCNT_W-1:0] word_bytes(input logic [1:0] sel);
    case (sel)
      SEL_WEIGHT: word_bytes = BCNT_W'(WEIGHT_SIZE / 8);
      SEL_OP:     word_bytes = BCNT_W'(OP_SIZE / 8);
      default:    word_bytes = BCNT_W'(DATA_SIZE / 8);
    endcase
  endfunction

  // True when the word address lies inside the selected memory.
  function automatic logic addr_ok(input logic [1:0] sel, input logic [15:0] addr);
    case (sel)
      SEL_WEIGHT: addr_ok = (32'(addr) < WEIGHT_ADDRS);
      SEL_OP:     addr_ok = (32'(addr) < OP_ADDRS);
      default:    addr_ok = (32'(addr) < DATA_ADDRS);
    endcase
  endfunction

  // Command FSM with registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= HDR0;
      r_cmd       <= '0;
      r_count     <= '0;
      r_word_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_wait      <= '0;
      r_addr      <= '0;
      r_sel       <= SEL_DATA;
      r_wdata     <= '0;
      r_rbuf      <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_cpu_start <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_cpu_start <= 1'b0;

      // Host bytes arriving while we cannot consume them are dropped.
      if (rx_valid && (r_state inside {WR_COMMIT, RD_ISSUE, RD_WAIT, RD_SEND, RUN_WAIT}))
        r_err <= 1'b1;

      case (r_state)
        HDR0: begin
          if (rx_valid) begin
            r_cmd   <= rx_data;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= HDR1;
          end
        end

        HDR1: begin
          if (rx_valid) begin
            r_count[7:0] <= rx_data;
            r_state      <= HDR2;
          end
        end

        HDR2: begin
          if (rx_valid) begin
            r_count[15:8] <= rx_data;
            r_addr        <= '0;
            r_word_cnt    <= '0;
            r_byte_cnt    <= '0;
            r_wdata       <= '0;
            case (r_cmd)
              CMD_WR_DATA: begin
                r_sel   <= SEL_DATA;
                r_state <= WR_BYTES;
              end
              CMD_WR_WEIGHT: begin
                r_sel   <= SEL_WEIGHT;
                r_state <= WR_BYTES;
              end
              CMD_WR_OP: begin
                r_sel   <= SEL_OP;
                r_state <= WR_BYTES;
              end
              CMD_RD_DATA: begin
                r_sel   <= SEL_DATA;
                r_re    <= addr_ok(SEL_DATA, 16'd0);
                r_state <= RD_ISSUE;
              end
              CMD_RD_WEIGHT: begin
                r_sel   <= SEL_WEIGHT;
                r_re    <= addr_ok(SEL_WEIGHT, 16'd0);
                r_state <= RD_ISSUE;
              end
              CMD_RUN: begin
                r_cpu_start <= 1'b1;
                r_state     <= RUN_WAIT;
              end
              default: begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= HDR0;
              end
            endcase
          end
        end

        // Assemble a word LSB-first; commit after its last byte.
        WR_BYTES: begin
          if (rx_valid) begin
            for (int unsigned k = 0; k < MAX_BYTES; k++) begin
              if (r_byte_cnt == BCNT_W'(k)) r_wdata[8*k +: 8] <= rx_data;
            end
            if (r_byte_cnt == word_bytes(r_sel) - BCNT_W'(1)) begin
              r_byte_cnt <= '0;
              r_we       <= addr_ok(r_sel, r_addr);
              if (!addr_ok(r_sel, r_addr)) r_err <= 1'b1;
              r_state    <= WR_COMMIT;
            end else begin
              r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end
          end
        end

        // mem_we is high this cycle; advance to the next word or finish.
        WR_COMMIT: begin
          r_addr  <= r_addr + 16'd1;
          r_wdata <= '0;
          if (r_word_cnt == {1'b0, r_count}) begin
`ifdef LOADER_AUTORUN_EN
            if (r_sel == SEL_OP) begin
              r_cpu_start <= 1'b1;
              r_state     <= RUN_WAIT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= HDR0;
            end
`else
            r_busy  <= 1'b0;
            r_state <= HDR0;
`endif
          end else begin
            r_word_cnt <= r_word_cnt + 17'd1;
            r_state    <= WR_BYTES;
          end
        end

        // mem_re was pulsed on entry (only for in-range addresses).
        RD_ISSUE: begin
          if (!addr_ok(r_sel, r_addr)) r_err <= 1'b1;
          r_wait  <= WAIT_W'(1);
          r_state <= RD_WAIT;
        end

        // Latch the word once the BRAM latency has elapsed.
        RD_WAIT: begin
          if (r_wait == WAIT_W'(READ_LATENCY)) begin
            if (addr_ok(r_sel, r_addr)) begin
              r_tx_data <= mem_rdata[7:0];
              r_rbuf    <= mem_rdata >> 8;
            end else begin
              r_tx_data <= 8'h00;
              r_rbuf    <= '0;
            end
            r_tx_valid <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= RD_SEND;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        // Shift the latched word out LSB-first under tx handshake.
        RD_SEND: begin
          if (r_tx_valid && tx_ready) begin
            if (r_byte_cnt == word_bytes(r_sel) - BCNT_W'(1)) begin
              r_tx_valid <= 1'b0;
              r_byte_cnt <= '0;
              r_addr     <= r_addr + 16'd1;
              if (r_word_cnt == {1'b0, r_count}) begin
                r_busy  <= 1'b0;
                r_state <= HDR0;
              end else begin
                r_word_cnt <= r_word_cnt + 17'd1;
                r_re       <= addr_ok(r_sel, r_addr + 16'd1);
                r_state    <= RD_ISSUE;
              end
            end else begin
              r_tx_data  <= r_rbuf[7:0];
              r_rbuf     <= r_rbuf >> 8;
              r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end
          end
        end

        RUN_WAIT: begin
          if (cpu_done) begin
            r_busy  <= 1'b0;
            r_state <= HDR0;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= HDR0;
        end
      endcase
    end
  end

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign mem_sel   = r_sel;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_re    = r_re;
  assign cpu_start = r_cpu_start;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_host_cmd_loader.sv
// tb_host_cmd_loader: randomized host traffic against a word-level model of the
// loader (memory contents, expected write events, expected tx byte stream).
module tb_host_cmd_loader;

  localparam int RL   = 2;
  localparam int MAXW = 96;

  logic            clk_in = 1'b0;
  logic            rst_n_in = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic [7:0]      tx_data;
  logic [1:0]      mem_sel;
  logic [15:0]     mem_addr;
  logic [MAXW-1:0] mem_wdata;
  logic            mem_we;
  logic            mem_re;
  logic [MAXW-1:0] mem_rdata = '0;
  logic            cpu_start;
  logic            cpu_done = 1'b0;
  logic            busy;
  logic            err;

  host_cmd_loader dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cpu_start (cpu_start),
    .cpu_done  (cpu_done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Emulated BRAMs (what the DUT actually wrote) and reference model memories.
  logic [MAXW-1:0] br_mem [4][16];
  logic [MAXW-1:0] m_mem  [4][16];
  logic            mdl_err = 1'b0;

  logic [113:0] obs_wr[$];
  logic [113:0] exp_wr[$];
  logic [7:0]   obs_tx[$];
  logic [7:0]   exp_tx[$];
  logic [7:0]   pl[$];
  int           n_start = 0;

  int           rd_cnt = -1;
  logic [MAXW-1:0] rd_word = '0;
  bit           rdy_rand = 0;
  int           stall_at = -1;
  int           stall_left = 0;
  bit           pend = 0;
  logic [7:0]   prev_data = 8'h00;

  // Observe DUT outputs mid-cycle; emulate BRAM, record events, drive tx_ready.
  always @(negedge clk_in) begin
    if (mem_we) begin
      obs_wr.push_back({mem_sel, mem_addr, mem_wdata});
      if (mem_addr < 16'd16) br_mem[mem_sel][mem_addr[3:0]] = mem_wdata;
    end
    if (rd_cnt > 0) rd_cnt--;
    if (rd_cnt == 0) begin
      mem_rdata = rd_word;
      rd_cnt = -1;
    end else begin
      mem_rdata = {$urandom, $urandom, $urandom};
    end
    if (mem_re) begin
      rd_word = (mem_addr < 16'd16) ? br_mem[mem_sel][mem_addr[3:0]] : '0;
      rd_cnt = RL;
    end
    if (cpu_start) n_start++;
    if (pend && rst_n_in)
      check_eq("tx_hold", 128'({tx_valid, tx_data}), 128'({1'b1, prev_data}));
    if (stall_left > 0 && obs_tx.size() == stall_at) begin
      tx_ready = 1'b0;
      stall_left--;
    end else if (rdy_rand) begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end else begin
      tx_ready = 1'b1;
    end
    if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
    pend = tx_valid && !tx_ready && rst_n_in;
    prev_data = tx_data;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 20000) begin
      @(negedge clk_in);
      cyc++;
    end
    check_eq("idle_timeout", 128'(busy), 128'(0));
  endtask

  function automatic int bytes_of(input logic [1:0] sel);
    return (sel == 2'd1) ? 12 : (sel == 2'd3) ? 1 : 8;
  endfunction

  function automatic int depth_of(input logic [1:0] sel);
    return (sel == 2'd3) ? 12 : 2;
  endfunction

  // Issue one command: build expectations from the model, drive it, compare.
  task automatic do_cmd(input logic [7:0] cmd, input logic [15:0] cnt, input bit directed);
    logic [1:0]      sel;
    logic [MAXW-1:0] word;
    int nb, depth, nw, exp_start;
    exp_wr.delete(); exp_tx.delete(); obs_wr.delete(); obs_tx.delete();
    n_start = 0;
    exp_start = 0;
    mdl_err = 1'b0;
    sel = (cmd == 8'h01 || cmd == 8'h05) ? 2'd1 : (cmd == 8'h03) ? 2'd3 : 2'd0;
    nb = bytes_of(sel);
    depth = depth_of(sel);
    nw = int'(cnt) + 1;
    case (cmd)
      8'h00, 8'h01, 8'h03: begin
        if (!directed) begin
          pl.delete();
          for (int i = 0; i < nw * nb; i++) pl.push_back(8'($urandom));
        end
        for (int w = 0; w < nw; w++) begin
          word = '0;
          for (int k = 0; k < nb; k++) word[8*k +: 8] = pl[w*nb + k];
          if (w < depth) begin
            exp_wr.push_back({sel, 16'(w), word});
            m_mem[sel][w] = word;
          end else begin
            mdl_err = 1'b1;
          end
        end
`ifdef LOADER_AUTORUN_EN
        if (cmd == 8'h03) exp_start = 1;
`endif
      end
      8'h04, 8'h05: begin
        for (int w = 0; w < nw; w++) begin
          word = (w < depth) ? m_mem[sel][w] : '0;
          if (w >= depth) mdl_err = 1'b1;
          for (int k = 0; k < nb; k++) exp_tx.push_back(word[8*k +: 8]);
        end
      end
      8'h02: exp_start = 1;
      default: mdl_err = 1'b1;
    endcase
    if (exp_start != 0) cpu_done = 1'b1;
    send_byte(cmd);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    if (cmd == 8'h00 || cmd == 8'h01 || cmd == 8'h03) begin
      foreach (pl[i]) begin
        send_byte(pl[i]);
        if (!directed) repeat ($urandom_range(0, 2)) @(negedge clk_in);
      end
    end
    wait_idle();
    repeat (3) @(negedge clk_in);
    cpu_done = 1'b0;
    check_eq("wr_count", 128'(obs_wr.size()), 128'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check_eq("wr_event", 128'(obs_wr[i]), 128'(exp_wr[i]));
    check_eq("tx_count", 128'(obs_tx.size()), 128'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      check_eq("tx_byte", 128'(obs_tx[i]), 128'(exp_tx[i]));
    check_eq("err", 128'(err), 128'(mdl_err));
    check_eq("cpu_start_n", 128'(n_start), 128'(exp_start));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  busy_drop;
    logic [7:0] c;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++) begin
        br_mem[s][a] = '0;
        m_mem[s][a]  = '0;
      end

    repeat (3) @(negedge clk_in);
    check_eq("rst_outputs", 128'({tx_valid, tx_data, mem_sel, mem_addr, mem_we, mem_re,
                                  cpu_start, busy, err}), 128'(0));
    check_eq("rst_wdata", 128'(mem_wdata), 128'(0));
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Single op word.
    pl.delete(); pl.push_back(8'h03);
    do_cmd(8'h03, 16'h0000, 1);

    // Two data words.
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'(8'h36 + i));
    for (int i = 0; i < 8; i++) pl.push_back(8'(8'h40 + i));
    do_cmd(8'h00, 16'h0001, 1);

    // Read them back with a 5-cycle stall mid-word.
    stall_at = 4; stall_left = 5;
    do_cmd(8'h04, 16'h0001, 1);
    stall_left = 0;

    // Three weight words into a two-deep memory, then a read clears err.
    do_cmd(8'h01, 16'h0002, 0);
    do_cmd(8'h05, 16'h0001, 0);

    // Run with cpu_done arriving 20 cycles later and a stray byte mid-wait.
    obs_wr.delete(); n_start = 0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    busy_drop = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (!busy) busy_drop = 1;
      if (i == 5) begin rx_data = 8'h55; rx_valid = 1'b1; end
      if (i == 6) rx_valid = 1'b0;
    end
    cpu_done = 1'b1;
    wait_idle();
    cpu_done = 1'b0;
    repeat (2) @(negedge clk_in);
    check_eq("run_start_n", 128'(n_start), 128'(1));
    check_eq("run_busy_held", 128'(busy_drop), 128'(0));
    check_eq("run_err_drop", 128'(err), 128'(1));
    check_eq("run_no_wr", 128'(obs_wr.size()), 128'(0));

    // cpu_done already high: exit one cycle after the start pulse.
    n_start = 0;
    cpu_done = 1'b1;
    send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk_in);
      cyc++;
    end
    cpu_done = 1'b0;
    check_eq("run_done_high_cyc", 128'(cyc), 128'(1));
    check_eq("run_done_high_n", 128'(n_start), 128'(1));
    check_eq("run_err_cleared", 128'(err), 128'(0));

    // Unknown command.
    do_cmd(8'h09, 16'h0003, 0);

    // Reset in the middle of a data word, then a clean write to address 0.
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check_eq("midrst_outputs", 128'({tx_valid, tx_data, mem_sel, mem_addr, mem_we, mem_re,
                                     cpu_start, busy, err}), 128'(0));
    check_eq("midrst_wdata", 128'(mem_wdata), 128'(0));
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'(8'hA0 + i));
    do_cmd(8'h00, 16'h0000, 1);
    do_cmd(8'h04, 16'h0000, 1);

    // Randomized command mix with random tx backpressure.
    rdy_rand = 1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0: c = 8'h00;
        1: c = 8'h01;
        2: c = 8'h03;
        3: c = 8'h04;
        4: c = 8'h05;
        5: c = 8'h02;
        6: c = 8'h03;
        default: c = 8'($urandom_range(6, 255));
      endcase
      if (c == 8'h03) do_cmd(c, 16'($urandom_range(0, 13)), 0);
      else            do_cmd(c, 16'($urandom_range(0, 3)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/host_cmd_loader.md
# host_cmd_loader

Host command controller between the UART byte receiver/transmitter and the CPU's memories. It parses a 3-byte command header from the host, streams payload bytes into the op, data or weight BRAM as full-width words, reads words back out over UART, and starts the CPU. It is the only writer of those BRAMs while the CPU is idle.

## Interface
- DATA_SIZE, 64, data word width in bits
- WEIGHT_SIZE, 96, weight word width in bits
- OP_SIZE, 8, op word width in bits
- DATA_ADDRS / WEIGHT_ADDRS / OP_ADDRS, 2 / 2 / 12, depth of each memory in words
- READ_LATENCY, 2, BRAM read latency in cycles
- MAX_SIZE, max(DATA_SIZE, WEIGHT_SIZE, OP_SIZE), derived, not overridable
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle strobe per received byte
- rx_data  input  8  received byte
- tx_valid  output  1  byte available for the UART transmitter
- tx_ready  input  1  transmitter accepts byte when high with tx_valid
- tx_data  output  8  byte to send
- mem_sel  output  2  0 = data, 1 = weight, 3 = op
- mem_addr  output  16  word address
- mem_wdata  output  MAX_SIZE  write word, zero-padded above the target width
- mem_we  output  1  one-cycle write strobe
- mem_re  output  1  one-cycle read strobe
- mem_rdata  input  MAX_SIZE  read word, valid READ_LATENCY cycles after mem_re
- cpu_start  output  1  one-cycle start pulse
- cpu_done  input  1  CPU finished
- busy  output  1  high in any state other than HDR0
- err  output  1  sticky error, cleared when the next header byte 0 is accepted

## Operation
- Header:
  - byte0 = command.
  - byte1 = count[7:0], byte2 = count[15:8].
  - Number of words = count+1.
- Commands:
  - 0x00: write data.
  - 0x01: write weight.
  - 0x03: write op.
  - 0x04: read data.
  - 0x05: read weight.
  - 0x02: run. The count field is ignored.
  - Any other value sets err and returns to HDR0.
- States:
  - HDR0 → HDR1 → HDR2, one state per byte, advancing on rx_valid.
  - From HDR2: WR_BYTES for write commands, RD_ISSUE for read commands, RUN_WAIT for run.
- Word widths in bytes:
  - data = DATA_SIZE/8 (8).
  - weight = WEIGHT_SIZE/8 (12).
  - op = OP_SIZE/8 (1).
- Writes:
  - Bytes arrive LSB-first. Byte k of a word goes to bits [8k+7:8k].
  - After the last byte of a word: one-cycle mem_we, then mem_addr+1.
  - After count+1 words: return to HDR0.
  - The address starts at 0 for every command.
  - Addresses ≥ the target depth: mem_we is suppressed, bytes are still consumed, and err is set.
- Reads:
  - RD_ISSUE pulses mem_re, then RD_WAIT for READ_LATENCY cycles and latches mem_rdata.
  - RD_SEND presents the latched bytes LSB-first on tx.
  - After the last byte of a word is accepted: mem_addr+1 and back to RD_ISSUE, or to HDR0 after count+1 words.
  - Out-of-range addresses send 0x00 bytes and set err.
- Run:
  - One-cycle cpu_start pulse, then RUN_WAIT until cpu_done, then HDR0.
- rx_valid received in RD_*, RUN_WAIT or WR_COMMIT: the byte is dropped and err is set.

## Timing
- Reset values: all outputs 0; state HDR0; address and byte counters 0.
- mem_we asserts the cycle after the rx_valid of the last byte of a word; mem_wdata and mem_addr are stable in that cycle.
- Read latency: mem_re to tx_valid = READ_LATENCY+1 cycles.
- tx handshake:
  - tx_valid stays high and tx_data stays stable until tx_ready.
  - The next byte is presented the cycle after acceptance.
- Count 0xFFFF = 65536 words. The counter is 17 bits internally and must not wrap.
- cpu_done already high when RUN_WAIT is entered: exit on the next cycle.
- Reset deassertion mid-operation: restart cleanly in HDR0 with no spurious mem_we, tx_valid or cpu_start.

## Configuration
- LOADER_AUTORUN_EN:
  - When defined, completing a 0x03 op write goes to RUN_WAIT with a cpu_start pulse in the cycle after the final mem_we, and no separate run command is needed.
  - When undefined, only command 0x02 starts the CPU.

## Test plan
- Header 03 00 00, then byte 0x03 → one mem_we with mem_sel=3, mem_addr=0, mem_wdata[7:0]=0x03; back in HDR0; err=0.
- Header 00 01 00, then bytes 36..3D and 40..47 → mem_we at addr 0 with wdata 0x3D3C3B3A39383736, then addr 1 with 0x4746454443424140.
- After the previous write, header 04 01 00 → tx bytes 36..3D, 40..47 in order. With tx_ready held low for 5 cycles mid-word, no byte is lost or duplicated.
- Header 01 02 00 (3 weight words into depth 2) → two mem_we, the third word is suppressed, err=1; next header byte 0 clears err.
- Header 02 00 00 with cpu_done rising 20 cycles later → a single cpu_start pulse, busy high throughout, rx bytes during the wait dropped with err=1. With LOADER_AUTORUN_EN, an op write alone produces the pulse.
- Reset asserted mid-data-word (after 4 of 8 bytes) → all outputs 0; a subsequent header 00 00 00 plus 8 bytes writes address 0 correctly.
